// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the MNIST convolution datapath.
package cnn_pkg;
  localparam int MNIST_W = 28;
  localparam int MNIST_H = 28;
  localparam int CONV_K  = 3;

  // Store tap feeding window element (r,c); row 0 / col 0 is the oldest pixel.
  function automatic int window_idx(input int r, input int c, input int k, input int w);
    return (k - 1 - r) * w + (k - 1 - c);
  endfunction
endpackage

// File: rtl/tap_shift_chain.sv
// Enable-gated shift chain with synchronous reset/clear to a load value; every stage is exposed.
module tap_shift_chain
  import cnn_pkg::*;
#(
  parameter int N     = 8,
  parameter int Depth = 59
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          rst_val_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [N-1:0]          data_i,
  output logic [Depth-1:0][N-1:0] stages_o
);
  logic [Depth-1:0][N-1:0] store_q, store_d;

  always_comb begin
    store_d = store_q;
    if (clear_i) begin
      store_d = {Depth{rst_val_i}};
    end else if (en_i) begin
      store_d[0] = data_i;
      for (int j = 1; j < Depth; j++) store_d[j] = store_q[j-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) store_q <= {Depth{rst_val_i}};
    else       store_q <= store_d;
  end

  assign stages_o = store_q;
endmodule

// File: rtl/conv_line_buffer.sv
// Raster-order pixel stream to K x K sliding window, with geometry tracking,
// window-valid qualification and end-of-frame pulse.
module conv_line_buffer
  import cnn_pkg::*;
#(
  parameter int N         = 8,
  parameter int ImgWidth  = MNIST_W,
  parameter int ImgHeight = MNIST_H,
  parameter int K         = CONV_K,
  localparam int Depth    = (K - 1) * ImgWidth + K,
  localparam int CW       = (ImgWidth  > 1) ? $clog2(ImgWidth)  : 1,
  localparam int RW       = (ImgHeight > 1) ? $clog2(ImgHeight) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  rst_val_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [N-1:0]  data_i,
  output logic [N-1:0]  window_o [K*K-1:0],
  output logic          win_valid_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          frame_done_o
);
  logic [Depth-1:0][N-1:0] taps;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          last_col, last_row;

  tap_shift_chain #(.N(N), .Depth(Depth)) u_chain (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rst_val_i(rst_val_i),
    .clear_i  (clear_i),
    .en_i     (en_i),
    .data_i   (data_i),
    .stages_o (taps)
  );

  assign last_col = (col_q == CW'(ImgWidth - 1));
  assign last_row = (row_q == RW'(ImgHeight - 1));

  // Qualification uses the pre-increment position, so row-straddling windows never fire.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      valid_d = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1);
      done_d  = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign window_o[r*K+c] = taps[window_idx(r, c, K, ImgWidth)];
    end
  end

  assign win_valid_o  = valid_q;
  assign frame_done_o = done_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
endmodule

// File: tb/tb_conv_line_buffer.sv
// Self-checking bench: table vectors, hand sequences and randomized traffic against a history-based model.
module tb_conv_line_buffer;
  localparam int W = 4, H = 4, K = 3, FR = W * H;

  logic clk = 0;
  always #5 clk = ~clk;

  // DUT 0: W=H=4, K=3
  logic       r0 = 1, c0 = 0, e0 = 0;
  logic [7:0] d0 = 0, rv0 = 8'h5C;
  logic [7:0] win0 [8:0];
  logic       v0, f0;
  logic [1:0] col0, row0;

  conv_line_buffer #(.N(8), .ImgWidth(W), .ImgHeight(H), .K(K)) dut0 (
    .clk_i(clk), .rst_i(r0), .rst_val_i(rv0), .clear_i(c0), .en_i(e0), .data_i(d0),
    .window_o(win0), .win_valid_o(v0), .col_o(col0), .row_o(row0), .frame_done_o(f0));

  // DUT 1: W=H=2, K=1
  logic       r1 = 1, c1 = 0, e1 = 0;
  logic [7:0] d1 = 0, rv1 = 8'h11;
  logic [7:0] win1 [0:0];
  logic       v1, f1;
  logic [0:0] col1, row1;

  conv_line_buffer #(.N(8), .ImgWidth(2), .ImgHeight(2), .K(1)) dut1 (
    .clk_i(clk), .rst_i(r1), .rst_val_i(rv1), .clear_i(c1), .en_i(e1), .data_i(d1),
    .window_o(win1), .win_valid_o(v1), .col_o(col1), .row_o(row1), .frame_done_o(f1));

  int vectors = 0, miscompares = 0;

  // Reference model: every accepted pixel since the last reset/clear, newest first.
  int  hist[$];
  int  rv_m = 0, pcnt = 0;
  bit  ev = 0, ed = 0;
  int  npulse = 0, ndone = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check0();
    int pos, age, exp;
    pos = pcnt % FR;
    chk("valid", int'(v0), int'(ev));
    chk("frame_done", int'(f0), int'(ed));
    chk("col", int'(col0), pos % W);
    chk("row", int'(row0), pos / W);
    for (int i = 0; i < K * K; i++) begin
      // Element (r,c) is the pixel accepted (K-1-r) rows and (K-1-c) columns before the newest.
      age = (K - 1 - i / K) * W + (K - 1 - i % K);
      exp = (age < hist.size()) ? hist[age] : rv_m;
      chk($sformatf("window[%0d]", i), int'(win0[i]), exp);
    end
  endtask

  task automatic step0(input bit rst, input bit clr, input bit en, input int d);
    int p;
    r0 = rst; c0 = clr; e0 = en; d0 = d[7:0];
    @(posedge clk); #1;
    if (rst || clr) begin
      hist.delete(); rv_m = int'(rv0); pcnt = 0; ev = 0; ed = 0;
    end else if (en) begin
      p  = pcnt % FR;
      ev = (p / W >= K - 1) && (p % W >= K - 1);
      ed = (p == FR - 1);
      hist.push_front(d & 255);
      if (hist.size() > 64) void'(hist.pop_back());
      pcnt++;
    end else begin
      ev = 0; ed = 0;
    end
    r0 = 0; c0 = 0; e0 = 0;
    check0();
    if (v0) npulse++;
    if (f0) ndone++;
  endtask

  typedef struct { int d; bit v; bit f; int col; int row; } vec_t;
  vec_t tbl[16];
  vec_t tbl1[4];
  int   w10[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int   w110[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

  initial begin
    int first;
    tbl[0]  = '{0, 0, 0, 1, 0};  tbl[1]  = '{1, 0, 0, 2, 0};
    tbl[2]  = '{2, 0, 0, 3, 0};  tbl[3]  = '{3, 0, 0, 0, 1};
    tbl[4]  = '{4, 0, 0, 1, 1};  tbl[5]  = '{5, 0, 0, 2, 1};
    tbl[6]  = '{6, 0, 0, 3, 1};  tbl[7]  = '{7, 0, 0, 0, 2};
    tbl[8]  = '{8, 0, 0, 1, 2};  tbl[9]  = '{9, 0, 0, 2, 2};
    tbl[10] = '{10, 1, 0, 3, 2}; tbl[11] = '{11, 1, 0, 0, 3};
    tbl[12] = '{12, 0, 0, 1, 3}; tbl[13] = '{13, 0, 0, 2, 3};
    tbl[14] = '{14, 1, 0, 3, 3}; tbl[15] = '{15, 1, 1, 0, 0};
    tbl1[0] = '{5, 1, 0, 1, 0};  tbl1[1] = '{6, 1, 0, 0, 1};
    tbl1[2] = '{7, 1, 0, 1, 1};  tbl1[3] = '{8, 1, 1, 0, 0};

    // Reset state (window all rst_val)
    step0(1, 0, 0, 0);
    step0(1, 0, 0, 0);
    chk("reset win[4]", int'(win0[4]), 8'h5C);

    // Frame 0..15, table-driven
    npulse = 0; ndone = 0;
    for (int i = 0; i < 16; i++) begin
      step0(0, 0, 1, tbl[i].d);
      chk("tbl valid", int'(v0), int'(tbl[i].v));
      chk("tbl done", int'(f0), int'(tbl[i].f));
      chk("tbl col", int'(col0), tbl[i].col);
      chk("tbl row", int'(row0), tbl[i].row);
      if (i == 10) for (int j = 0; j < 9; j++) chk("first window", int'(win0[j]), w10[j]);
    end
    chk("frame pulses", npulse, 4);
    chk("frame dones", ndone, 1);

    // Same stream with idle cycles in between
    step0(1, 0, 0, 0);
    npulse = 0;
    for (int i = 0; i < 16; i++) begin
      step0(0, 0, 1, i);
      step0(0, 0, 0, 0);
    end
    chk("gapped pulses", npulse, 4);

    // Back-to-back frames
    step0(1, 0, 0, 0);
    npulse = 0; ndone = 0;
    for (int i = 0; i < 16; i++) step0(0, 0, 1, i);
    for (int i = 0; i < 16; i++) begin
      step0(0, 0, 1, 100 + i);
      if (i == 10) for (int j = 0; j < 9; j++) chk("frame2 window", int'(win0[j]), w110[j]);
    end
    chk("b2b pulses", npulse, 8);
    chk("b2b dones", ndone, 2);

    // Clear with en at pixel 6
    step0(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step0(0, 0, 1, i);
    rv0 = 8'hAA;
    step0(0, 1, 1, 6);
    chk("clear win[0]", int'(win0[0]), 8'hAA);
    chk("clear win[8]", int'(win0[8]), 8'hAA);
    chk("clear col", int'(col0), 0);
    chk("clear row", int'(row0), 0);
    npulse = 0;
    for (int i = 0; i < 16; i++) step0(0, 0, 1, i);
    chk("post-clear pulses", npulse, 4);

    // Reset mid-frame with en
    for (int i = 0; i < 7; i++) step0(0, 0, 1, i);
    rv0 = 8'h3C;
    step0(1, 0, 1, 7);
    chk("midrst valid", int'(v0), 0);
    chk("midrst win[8]", int'(win0[8]), 8'h3C);
    first = -1;
    for (int i = 0; i < 11; i++) begin
      step0(0, 0, 1, 20 + i);
      if (v0 && first < 0) first = i;
    end
    chk("midrst first pulse", first, 10);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rv0 = 8'($urandom);
      step0($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 9) < 7, int'($urandom_range(0, 255)));
    end

    // K=1, 2x2 image
    r1 = 1;
    @(posedge clk); #1;
    r1 = 0;
    chk("k1 reset win", int'(win1[0]), 8'h11);
    chk("k1 reset valid", int'(v1), 0);
    for (int i = 0; i < 4; i++) begin
      e1 = 1; d1 = 8'(tbl1[i].d);
      @(posedge clk); #1;
      e1 = 0;
      chk("k1 window", int'(win1[0]), tbl1[i].d);
      chk("k1 valid", int'(v1), int'(tbl1[i].v));
      chk("k1 done", int'(f1), int'(tbl1[i].f));
      chk("k1 col", int'(col1), tbl1[i].col);
      chk("k1 row", int'(row1), tbl1[i].row);
    end
    @(posedge clk); #1;
    chk("k1 idle valid", int'(v1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
- Streaming line buffer that turns a raster-order pixel stream into a K x K sliding window for the convolution stages of the MNIST datapath.
- Internally it is a tapped shift chain of depth (K-1)*ImgWidth+K, with row/column tracking and window-valid generation.
- Sits between the input pixel source and the MAC array.
- Next generation of the plain store-tapped shift register. It adds image geometry, frame restart, valid qualification and end-of-frame signalling.

Parameters:
- N, 8, pixel width in bits
- ImgWidth, 28, pixels per row; must be >= K
- ImgHeight, 28, rows per frame; must be >= K
- K, 3, kernel side; must be >= 1
- Derived: Depth = (K-1)*ImgWidth+K; CW = max(1,$clog2(ImgWidth)); RW = max(1,$clog2(ImgHeight))

Ports:
- clk_i, input, 1, clock; all logic on rising edge
- rst_i, input, 1, synchronous active-high reset
- rst_val_i, input, N, value loaded into every storage stage on rst_i or clear_i
- clear_i, input, 1, synchronous frame restart
- en_i, input, 1, pixel accepted this cycle
- data_i, input, N, pixel value
- window_o, output, N x K*K (unpacked [K*K-1:0]), current window
- win_valid_o, output, 1, window_o holds a complete in-image window
- col_o, output, CW, column index of the next pixel expected
- row_o, output, RW, row index of the next pixel expected
- frame_done_o, output, 1, one-cycle pulse after the last pixel of a frame

Behaviour:
- Priority is rst_i > clear_i > en_i. All updates are synchronous; there is no asynchronous path.
- rst_i or clear_i: every store stage <= rst_val_i; col/row <= 0; win_valid_o <= 0; frame_done_o <= 0. Any en_i in the same cycle is dropped.
- en_i=1 (no rst/clear):
  - store[0] <= data_i and store[j] <= store[j-1] for j=1..Depth-1.
  - If col==ImgWidth-1, col <= 0 and row advances; otherwise col <= col+1.
  - When row==ImgHeight-1 and col==ImgWidth-1, row <= 0.
- en_i=0: storage and counters hold; win_valid_o <= 0; frame_done_o <= 0.
- Window mapping: window_o[r*K+c] = store[(K-1-r)*ImgWidth + (K-1-c)] for r,c in 0..K-1.
  - Index 0 is the top-left (oldest) pixel; index K*K-1 is the newest pixel.
  - window_o is combinational from store; it is visible the cycle after acceptance.
- win_valid_o is registered. It is set to 1 in the cycle after an accepted pixel whose pre-increment (row,col) satisfies row >= K-1 and col >= K-1; otherwise it is 0.
  - It is a single-cycle pulse per qualifying pixel.
  - Windows that straddle a row boundary are never flagged.
  - Result: exactly (ImgWidth-K+1)*(ImgHeight-K+1) pulses per frame.
- frame_done_o is registered. It pulses 1 the cycle after the pixel at (ImgHeight-1, ImgWidth-1) is accepted, coincident with that pixel's win_valid_o pulse.
- Frame wrap: storage is not cleared between frames. Stale rows are masked by the row qualification, so back-to-back frames need no gap.
- K=1: Depth=1, window_o[0]=store[0], and every accepted pixel produces a pulse.
- Latency: pixel in at cycle t gives window/valid at t+1. Throughput is one pixel per cycle.
- Reset values: window_o = all rst_val_i; win_valid_o=0; frame_done_o=0; col_o=0; row_o=0.

Decomposition:
- Shared package cnn_pkg holds:
  - function window_idx(r,c,K,ImgWidth) returning the store tap index;
  - localparam defaults MNIST_W=28, MNIST_H=28, CONV_K=3.
- One sub-module: tap_shift_chain (N, Depth). It is the enable-gated shift chain with sync reset/clear to rst_val_i and exposes all stages.
- conv_line_buffer owns the counters, qualification, tap selection and pulses.

Test Plan:
- N=8, W=4, H=4, K=3; feed pixels 0..15 with en_i every cycle -> first win_valid_o the cycle after pixel 10 with window_o={0,1,2,4,5,6,8,9,10}; pulses after pixels 10, 11, 14, 15 only (4 total); frame_done_o with pixel 15's pulse; col_o/row_o back to 0.
- Same stream with en_i low on alternate cycles -> identical window sequence; win_valid_o never high in a cycle following en_i=0; counters frozen during gaps.
- Two back-to-back frames (pixels 0..15 then 100..115) -> second frame's first pulse after pixel 110 with window_o={100,101,102,104,105,106,108,109,110}; 8 pulses total; two frame_done_o pulses.
- clear_i asserted together with en_i at pixel 6, rst_val_i=8'hAA -> pixel 6 dropped; window_o all 8'hAA; col_o=row_o=0; restarted frame 0..15 behaves as scenario 1.
- rst_i high mid-frame while en_i=1 -> next cycle all outputs at reset values; win_valid_o stays 0 until 11 new pixels (row 2, col 2) have been accepted.
- K=1, W=H=2: feed 5,6,7,8 -> win_valid_o pulses 4 times with window_o[0]=5,6,7,8; frame_done_o after 8.
